// File: rtl/cpu_core_mc_if.sv
// Instruction- and data-memory request/acknowledge bus between cpu_core_mc and its memory wrappers.
interface cpu_core_mc_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 26,
  parameter int unsigned DADDR_W = 8,
  parameter int unsigned DATA_W  = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Parametrised multi-cycle core: FETCH/EXEC/MEM/HALTED with req/ack handshakes on both memories.
module cpu_core_mc #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RA_W    = 2,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned DADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  cpu_core_mc_if.master bus,
  output logic          retire,
  output logic          halted
);
  localparam int unsigned REG_N   = 2**RA_W;
  localparam int unsigned INSTR_W = 4 + 3*RA_W + IMM_W;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LDI, OP_LD, OP_ST, OP_JMP, OP_BZ, OP_BC, OP_BGT, OP_HALT
  } op_t;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

  state_t             r_state, w_next;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_regs [REG_N];
  logic               r_z, r_c, r_g;
  logic [DADDR_W-1:0] r_daddr;
  logic [DATA_W-1:0]  r_dwdata;
  logic               r_dwe;

  op_t                w_op;
  logic [RA_W-1:0]    w_rd, w_ra, w_rb;
  logic [IMM_W-1:0]   w_imm;
  logic [DATA_W-1:0]  w_a, w_b, w_res;
  logic               w_c, w_alu, w_taken;

  assign w_op  = op_t'(r_ir[INSTR_W-1 -: 4]);
  assign w_rd  = r_ir[INSTR_W-5 -: RA_W];
  assign w_ra  = r_ir[INSTR_W-5-RA_W -: RA_W];
  assign w_rb  = r_ir[INSTR_W-5-2*RA_W -: RA_W];
  assign w_imm = r_ir[IMM_W-1:0];
  assign w_a   = r_regs[w_ra];
  assign w_b   = r_regs[w_rb];

  assign bus.imem_addr  = r_pc;
  assign bus.dmem_addr  = r_daddr;
  assign bus.dmem_wdata = r_dwdata;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_alu = 1'b1;
    case (w_op)
      OP_ADD: {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB: begin
        w_res = w_a - w_b;
        w_c   = (w_a < w_b);
      end
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_SHL: begin
        w_res = {w_a[DATA_W-2:0], 1'b0};
        w_c   = w_a[DATA_W-1];
      end
      OP_SHR: begin
        w_res = {1'b0, w_a[DATA_W-1:1]};
        w_c   = w_a[0];
      end
      default: w_alu = 1'b0;
    endcase
  end

  always_comb begin
    case (w_op)
      OP_JMP:  w_taken = 1'b1;
      OP_BZ:   w_taken = r_z;
      OP_BC:   w_taken = r_c;
      OP_BGT:  w_taken = r_g;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) w_next = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_LD, OP_ST: w_next = S_MEM;
          OP_HALT: begin
            retire = 1'b1;
            w_next = S_HALTED;
          end
          default: begin
            retire = 1'b1;
            w_next = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = r_dwe;
        if (bus.dmem_ack) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      default: halted = 1'b1;
    endcase
    // State already snaps to FETCH asynchronously; this keeps imem_req low while rst is held.
    if (rst) begin
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      retire       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_ir     <= '0;
      for (int unsigned i = 0; i < REG_N; i++) r_regs[i] <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_g      <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dwe    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_ir <= bus.imem_rdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_EXEC: begin
          if (w_alu) begin
            r_regs[w_rd] <= w_res;
            r_z          <= (w_res == '0);
            r_c          <= w_c;
            r_g          <= (w_a > w_b);
          end
          if (w_op == OP_LDI) r_regs[w_rd] <= DATA_W'(w_imm);
          if (w_taken)        r_pc <= PC_W'(w_imm);
          if (w_op == OP_LD || w_op == OP_ST) begin
            r_daddr  <= DADDR_W'(w_a) + DADDR_W'(w_imm);
            r_dwdata <= w_b;
            r_dwe    <= (w_op == OP_ST);
          end
        end
        S_MEM: begin
          if (bus.dmem_ack && !r_dwe) r_regs[w_rd] <= bus.dmem_rdata;
        end
        default: ;
      endcase
    end
  end
endmodule
